// File: rtl/branch_pht_resolver.sv
// branch_pht_resolver
//   Pattern history table of 2-bit saturating counters. Lookups from fetch
//   read a counter and issue a registered prediction one cycle later.
//   Resolves from execute retire in-flight branches in order, train the
//   counter and report mispredictions.
//
// Ports
//   clk, reset    rising-edge clock, async active-high reset
//   lkp_valid     lookup request          lkp_idx   table index
//   lkp_ready     room for another in-flight branch
//   pred_valid    prediction valid (1 cycle after acceptance)
//   pred_taken    predicted direction (holds when no new prediction)
//   res_valid     outcome of oldest in-flight branch
//   res_torn      actual outcome, 1 = taken
//   res_ack       pulse: an entry was resolved
//   res_mispred   pulse with res_ack: stored prediction was wrong
//   res_err       pulse: resolve arrived with nothing in flight
//   inflight      current in-flight count
//   mis_cnt       saturating misprediction count
module branch_pht_resolver #(
  parameter int IDX_W = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       lkp_valid,
  input  logic [IDX_W-1:0]           lkp_idx,
  output logic                       lkp_ready,
  output logic                       pred_valid,
  output logic                       pred_taken,
  input  logic                       res_valid,
  input  logic                       res_torn,
  output logic                       res_ack,
  output logic                       res_mispred,
  output logic                       res_err,
  output logic [$clog2(DEPTH):0]     inflight,
  output logic [CNT_W-1:0]           mis_cnt
);

  localparam int TBL   = 2**IDX_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [1:0]       pht [TBL];
  logic [IDX_W-1:0] fifo_idx  [DEPTH];
  logic             fifo_pred [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic             push;
  logic             pop;
  logic [IDX_W-1:0] res_idx;
  logic             res_pred;
  logic [1:0]       cnt_cur;
  logic [1:0]       cnt_upd;
  logic             mis_now;

  // Ready depends only on the registered count, so a same-cycle resolve
  // never frees a slot for a lookup in that cycle.
  assign lkp_ready = (inflight < DEPTH_C);
  assign push      = lkp_valid && lkp_ready;
  assign pop       = res_valid && (inflight != '0);
  assign res_idx   = fifo_idx[rd_ptr];
  assign res_pred  = fifo_pred[rd_ptr];
  assign cnt_cur   = pht[res_idx];
  assign mis_now   = pop && (res_pred != res_torn);

  always_comb begin
    cnt_upd = cnt_cur;
    if (res_torn) begin
      if (cnt_cur != 2'b11) cnt_upd = cnt_cur + 2'b01;
    end else begin
      if (cnt_cur != 2'b00) cnt_upd = cnt_cur - 2'b01;
    end
  end

  // FIFO payload needs no reset; occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr]  <= lkp_idx;
      fifo_pred[wr_ptr] <= pht[lkp_idx][1];
    end
  end

  // The lookup reads pht before the nonblocking update lands, giving
  // read-before-write when both touch the same index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TBL; i++) pht[i] <= 2'b01;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      inflight    <= '0;
      mis_cnt     <= '0;
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      res_ack     <= 1'b0;
      res_mispred <= 1'b0;
      res_err     <= 1'b0;
    end else begin
      pred_valid  <= push;
      res_ack     <= pop;
      res_mispred <= mis_now;
      res_err     <= res_valid && (inflight == '0);

      if (push) begin
        pred_taken <= pht[lkp_idx][1];
        wr_ptr     <= wr_ptr + PTR_W'(1);
      end

      if (pop) begin
        pht[res_idx] <= cnt_upd;
        rd_ptr       <= rd_ptr + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase

      if (mis_now && (mis_cnt != '1)) mis_cnt <= mis_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_pht_resolver.sv
module tb_branch_pht_resolver;

  logic       clk = 1'b0;
  logic       reset;
  logic       lkp_valid;
  logic [3:0] lkp_idx;
  logic       lkp_ready;
  logic       pred_valid;
  logic       pred_taken;
  logic       res_valid;
  logic       res_torn;
  logic       res_ack;
  logic       res_mispred;
  logic       res_err;
  logic [2:0] inflight;
  logic [7:0] mis_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  branch_pht_resolver #(.IDX_W(4), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .lkp_valid(lkp_valid), .lkp_idx(lkp_idx), .lkp_ready(lkp_ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_torn(res_torn),
    .res_ack(res_ack), .res_mispred(res_mispred), .res_err(res_err),
    .inflight(inflight), .mis_cnt(mis_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus; outputs are sampled 1ns after the edge.
  task automatic step(input logic lv, input logic [3:0] li, input logic rv, input logic rt);
    lkp_valid = lv;
    lkp_idx   = li;
    res_valid = rv;
    res_torn  = rt;
    @(posedge clk);
    #1;
    lkp_valid = 1'b0;
    res_valid = 1'b0;
    res_torn  = 1'b0;
  endtask

  // Lookup idx then resolve it; check prediction and mispredict flag.
  task automatic pair(input string tag, input logic [3:0] idx, input logic rt,
                      input logic exp_pred, input logic exp_mis);
    step(1'b1, idx, 1'b0, 1'b0);
    check({tag, "_pred_valid"}, 32'(pred_valid), 32'd1);
    check({tag, "_pred"}, 32'(pred_taken), 32'(exp_pred));
    step(1'b0, 4'd0, 1'b1, rt);
    check({tag, "_ack"}, 32'(res_ack), 32'd1);
    check({tag, "_mis"}, 32'(res_mispred), 32'(exp_mis));
  endtask

  initial begin
    reset = 1'b1; lkp_valid = 1'b0; lkp_idx = '0; res_valid = 1'b0; res_torn = 1'b0;
    #12;
    check("rst_pred_valid", 32'(pred_valid), 32'd0);
    check("rst_pred_taken", 32'(pred_taken), 32'd0);
    check("rst_inflight", 32'(inflight), 32'd0);
    check("rst_mis_cnt", 32'(mis_cnt), 32'd0);
    check("rst_res_ack", 32'(res_ack), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_lkp_ready", 32'(lkp_ready), 32'd1);

    // First lookup of idx 3: weak not-taken
    step(1'b1, 4'd3, 1'b0, 1'b0);
    check("first_pred_valid", 32'(pred_valid), 32'd1);
    check("first_pred", 32'(pred_taken), 32'd0);
    check("first_inflight", 32'(inflight), 32'd1);
    step(1'b0, 4'd0, 1'b1, 1'b1);      // 01 -> 10, mispredict
    check("train1_ack", 32'(res_ack), 32'd1);
    check("train1_mis", 32'(res_mispred), 32'd1);
    check("train1_inflight", 32'(inflight), 32'd0);
    check("idle_pred_valid", 32'(pred_valid), 32'd0);
    pair("train2", 4'd3, 1'b1, 1'b1, 1'b0);   // 10 -> 11
    check("train_mis_cnt", 32'(mis_cnt), 32'd1);

    // Saturation at strong taken
    for (int i = 0; i < 3; i++) pair("sat_t", 4'd3, 1'b1, 1'b1, 1'b0);
    // Walk down: 11->10->01->00->00
    pair("nt1", 4'd3, 1'b0, 1'b1, 1'b1);
    pair("nt2", 4'd3, 1'b0, 1'b1, 1'b1);
    pair("nt3", 4'd3, 1'b0, 1'b0, 1'b0);
    pair("nt4", 4'd3, 1'b0, 1'b0, 1'b0);
    check("nt_mis_cnt", 32'(mis_cnt), 32'd3);

    // Fill the FIFO
    step(1'b1, 4'd0, 1'b0, 1'b0);
    step(1'b1, 4'd1, 1'b0, 1'b0);
    step(1'b1, 4'd2, 1'b0, 1'b0);
    check("fill3_ready", 32'(lkp_ready), 32'd1);
    step(1'b1, 4'd4, 1'b0, 1'b0);
    check("full_inflight", 32'(inflight), 32'd4);
    check("full_ready", 32'(lkp_ready), 32'd0);
    step(1'b1, 4'd7, 1'b0, 1'b0);
    check("full_rej_pv", 32'(pred_valid), 32'd0);
    check("full_rej_inflight", 32'(inflight), 32'd4);
    // Resolve while full plus a lookup attempt: lookup still refused
    step(1'b1, 4'd7, 1'b1, 1'b0);
    check("full_res_ack", 32'(res_ack), 32'd1);
    check("full_res_mis", 32'(res_mispred), 32'd0);
    check("full_res_pv", 32'(pred_valid), 32'd0);
    check("full_res_inflight", 32'(inflight), 32'd3);
    check("full_res_ready", 32'(lkp_ready), 32'd1);
    // Drain; idx1 taken (pred 0 -> mispredict), idx2/idx4 not-taken
    step(1'b0, 4'd0, 1'b1, 1'b1);
    check("drain1_mis", 32'(res_mispred), 32'd1);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    check("drain2_mis", 32'(res_mispred), 32'd0);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    check("drain_inflight", 32'(inflight), 32'd0);
    check("drain_mis_cnt", 32'(mis_cnt), 32'd4);
    pair("idx1_trained", 4'd1, 1'b1, 1'b1, 1'b0);   // idx1 now 10 -> 11

    // Same-cycle lookup and resolve on idx 5 (counter 01)
    step(1'b1, 4'd5, 1'b0, 1'b0);
    check("same_pre_pred", 32'(pred_taken), 32'd0);
    step(1'b1, 4'd5, 1'b1, 1'b1);
    check("same_pred", 32'(pred_taken), 32'd0);
    check("same_pv", 32'(pred_valid), 32'd1);
    check("same_ack", 32'(res_ack), 32'd1);
    check("same_mis", 32'(res_mispred), 32'd1);
    check("same_inflight", 32'(inflight), 32'd1);
    step(1'b1, 4'd5, 1'b1, 1'b1);                  // reads 10, writes 11
    check("same_next_pred", 32'(pred_taken), 32'd1);
    check("same_next_mis", 32'(res_mispred), 32'd1);
    step(1'b0, 4'd0, 1'b1, 1'b1);
    check("same_last_mis", 32'(res_mispred), 32'd0);
    check("same_inflight0", 32'(inflight), 32'd0);
    check("same_mis_cnt", 32'(mis_cnt), 32'd6);

    // Resolve with nothing in flight
    step(1'b0, 4'd0, 1'b1, 1'b0);
    check("err_pulse", 32'(res_err), 32'd1);
    check("err_ack", 32'(res_ack), 32'd0);
    check("err_inflight", 32'(inflight), 32'd0);
    check("err_mis_cnt", 32'(mis_cnt), 32'd6);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    check("err_clear", 32'(res_err), 32'd0);
    step(1'b1, 4'd5, 1'b0, 1'b0);
    check("err_keep5", 32'(pred_taken), 32'd1);
    step(1'b1, 4'd3, 1'b0, 1'b0);
    check("err_keep3", 32'(pred_taken), 32'd0);
    step(1'b1, 4'd1, 1'b0, 1'b0);
    check("err_keep1", 32'(pred_taken), 32'd1);
    check("pre_rst_inflight", 32'(inflight), 32'd3);

    // Reset with 3 in flight
    #2; reset = 1'b1; #1;
    check("mid_rst_inflight", 32'(inflight), 32'd0);
    check("mid_rst_mis_cnt", 32'(mis_cnt), 32'd0);
    check("mid_rst_pv", 32'(pred_valid), 32'd0);
    @(posedge clk); #2; reset = 1'b0;
    step(1'b0, 4'd0, 1'b0, 1'b0);
    check("post_rst_ack", 32'(res_ack), 32'd0);
    step(1'b1, 4'd5, 1'b0, 1'b0);
    check("post_rst_pred5", 32'(pred_taken), 32'd0);
    check("post_rst_pv", 32'(pred_valid), 32'd1);
    check("post_rst_ack2", 32'(res_ack), 32'd0);
    step(1'b0, 4'd0, 1'b1, 1'b1);
    check("post_rst_res_ack", 32'(res_ack), 32'd1);
    check("post_rst_res_mis", 32'(res_mispred), 32'd1);
    check("post_rst_mis_cnt", 32'(mis_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
